// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART capture receiver.
// Imported by the receiver top level.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // FIFO entry layout is {frame_err, parity_err, data}
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with extra-bit pointers.
// The read port is forced to zero while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot a same-cycle push needs when full
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign count   = wr_ptr - rd_ptr;
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_capture.sv
// UART receiver: mid-bit sampling FSM, error latches and
// an output FIFO with ready/valid drain and overrun pulse.
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 106,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        out_data,
    output logic                        out_parity_err,
    output logic                        out_frame_err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy
);

    localparam int EW = entry_width(DATA_BITS);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT/2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
    localparam logic          SLST = 1'(STOP_BITS - 1);
    localparam logic          ODD  = (PARITY == PAR_ODD);

    logic                 rx_meta;
    logic                 rxs;
    state_t               state, state_nx;
    logic [TW-1:0]        cnt, cnt_nx;
    logic [BW-1:0]        bit_idx, bit_idx_nx;
    logic                 stop_idx, stop_idx_nx;
    logic [DATA_BITS-1:0] shreg, shreg_nx;
    logic                 par_err, par_err_nx;
    logic                 frm_err, frm_err_nx;
    logic                 push_req;
    logic                 expired;

    logic                 f_full;
    logic                 f_empty;
    logic                 f_pop;
    logic [EW-1:0]        f_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign expired = (cnt == '0);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        bit_idx_nx  = bit_idx;
        stop_idx_nx = stop_idx;
        shreg_nx    = shreg;
        par_err_nx  = par_err;
        frm_err_nx  = frm_err;
        push_req    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_nx = ST_START;
                    cnt_nx   = HALF;
                end
            end
            ST_START: begin
                if (!expired) begin
                    cnt_nx = cnt - TW'(1);
                end else if (rxs) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx   = ST_DATA;
                    cnt_nx     = FULL;
                    bit_idx_nx = '0;
                    par_err_nx = 1'b0;
                    frm_err_nx = 1'b0;
                end
            end
            ST_DATA: begin
                if (!expired) begin
                    cnt_nx = cnt - TW'(1);
                end else begin
                    cnt_nx     = FULL;
                    shreg_nx   = {rxs, shreg[DATA_BITS-1:1]};
                    bit_idx_nx = bit_idx + BW'(1);
                    if (bit_idx == LAST) begin
                        stop_idx_nx = 1'b0;
                        state_nx    = (PARITY != PAR_NONE) ?
                                      ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (!expired) begin
                    cnt_nx = cnt - TW'(1);
                end else begin
                    cnt_nx      = FULL;
                    stop_idx_nx = 1'b0;
                    state_nx    = ST_STOP;
                    if ((^shreg ^ rxs) != ODD) par_err_nx = 1'b1;
                end
            end
            ST_STOP: begin
                if (!expired) begin
                    cnt_nx = cnt - TW'(1);
                end else begin
                    cnt_nx      = FULL;
                    stop_idx_nx = stop_idx + 1'b1;
                    if (!rxs) frm_err_nx = 1'b1;
                    if (stop_idx == SLST) begin
                        push_req = 1'b1;
                        state_nx = frm_err_nx ? ST_BREAK : ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            bit_idx  <= bit_idx_nx;
            stop_idx <= stop_idx_nx;
            shreg    <= shreg_nx;
            par_err  <= par_err_nx;
            frm_err  <= frm_err_nx;
        end
    end

    assign f_pop   = out_valid && out_ready;
    assign overrun = push_req && f_full && !f_pop;
    assign busy    = (state != ST_IDLE);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data ({frm_err_nx, par_err, shreg}),
        .pop       (f_pop),
        .full      (f_full),
        .empty     (f_empty),
        .count     (fifo_count),
        .rd_data   (f_head)
    );

    assign out_valid      = !f_empty;
    assign out_data       = f_head[DATA_BITS-1:0];
    assign out_parity_err = f_head[DATA_BITS];
    assign out_frame_err  = f_head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: three parameter sets
// driven one after another from a single stimulus sequence.
module tb_uart_rx_capture;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic       rx0 = 1'b1, rdy0 = 1'b0;
    logic [7:0] od0;
    logic       pe0, fe0, ov0, ovr0, bsy0;
    logic [4:0] cnt0;

    logic       rx1 = 1'b1, rdy1 = 1'b0;
    logic [6:0] od1;
    logic       pe1, fe1, ov1, ovr1, bsy1;
    logic [4:0] cnt1;

    logic       rx2 = 1'b1, rdy2 = 1'b0;
    logic [7:0] od2;
    logic       pe2, fe2, ov2, ovr2, bsy2;
    logic [2:0] cnt2;

    int n_vec = 0;
    int n_err = 0;
    int got_c;
    logic [7:0] got_d;
    logic got_pe, got_fe;
    int ovr_seen;

    always #5 clock = ~clock;

    uart_rx_capture u0 (
        .clock(clock), .reset(reset), .rx(rx0),
        .out_data(od0), .out_parity_err(pe0),
        .out_frame_err(fe0), .out_valid(ov0),
        .out_ready(rdy0), .overrun(ovr0),
        .fifo_count(cnt0), .busy(bsy0)
    );

    uart_rx_capture #(
        .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2)
    ) u1 (
        .clock(clock), .reset(reset), .rx(rx1),
        .out_data(od1), .out_parity_err(pe1),
        .out_frame_err(fe1), .out_valid(ov1),
        .out_ready(rdy1), .overrun(ovr1),
        .fifo_count(cnt1), .busy(bsy1)
    );

    uart_rx_capture #(
        .CLKS_PER_BIT(16), .FIFO_DEPTH(4)
    ) u2 (
        .clock(clock), .reset(reset), .rx(rx2),
        .out_data(od2), .out_parity_err(pe2),
        .out_frame_err(fe2), .out_valid(ov2),
        .out_ready(rdy2), .overrun(ovr2),
        .fifo_count(cnt2), .busy(bsy2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int w, input logic v);
        case (w)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // v[0] goes out first; each bit is held for cpb cycles
    task automatic send_bits(input int w, input int cpb,
                             input int n,
                             input logic [11:0] v);
        for (int i = 0; i < n; i++) begin
            set_rx(w, v[i]);
            repeat (cpb) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", ov0, 0);
        chk("rst_data", od0, 0);
        chk("rst_perr", pe0, 0);
        chk("rst_ferr", fe0, 0);
        chk("rst_overrun", ovr0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_busy", bsy0, 0);

        // 8N1 0x41, consumer always ready
        rdy0 = 1'b1;
        fork
            send_bits(0, 106, 10, {1'b1, 8'h41, 1'b0});
            begin
                int c = 0;
                while (!ov0 && c < 1200) begin
                    tick();
                    c++;
                end
                got_c  = c;
                got_d  = od0;
                got_pe = pe0;
                got_fe = fe0;
            end
        join
        chk("t1_latency_ok",
            32'(got_c >= 1000 && got_c <= 1020), 1);
        chk("t1_data", got_d, 'h41);
        chk("t1_perr", got_pe, 0);
        chk("t1_ferr", got_fe, 0);
        chk("t1_count", cnt0, 0);
        chk("t1_valid", ov0, 0);
        chk("t1_busy", bsy0, 0);

        // short low glitch
        set_rx(0, 1'b0);
        repeat (10) tick();
        chk("gl_busy_hi", bsy0, 1);
        repeat (10) tick();
        set_rx(0, 1'b1);
        repeat (80) tick();
        chk("gl_busy_lo", bsy0, 0);
        chk("gl_valid", ov0, 0);
        chk("gl_count", cnt0, 0);

        // framing error then line held low
        rdy0 = 1'b0;
        send_bits(0, 106, 10, {1'b0, 8'h3C, 1'b0});
        repeat (3 * 106) tick();
        chk("fe_busy", bsy0, 1);
        chk("fe_count", cnt0, 1);
        chk("fe_data", od0, 'h3C);
        chk("fe_ferr", fe0, 1);
        chk("fe_perr", pe0, 0);
        set_rx(0, 1'b1);
        repeat (10) tick();
        chk("fe_busy_rel", bsy0, 0);
        repeat (300) tick();
        chk("fe_no_more", cnt0, 1);
        rdy0 = 1'b1;
        tick();
        chk("fe_drained", cnt0, 0);
        rdy0 = 1'b0;

        // reset mid-frame with two queued entries
        send_bits(0, 106, 10, {1'b1, 8'h11, 1'b0});
        send_bits(0, 106, 10, {1'b1, 8'h22, 1'b0});
        chk("rm_count2", cnt0, 2);
        send_bits(0, 106, 3, {2'b10, 1'b0});
        chk("rm_busy_pre", bsy0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_rx(0, 1'b1);
        chk("rm_count0", cnt0, 0);
        chk("rm_valid0", ov0, 0);
        chk("rm_busy0", bsy0, 0);
        repeat (1200) tick();
        chk("rm_no_partial", cnt0, 0);
        send_bits(0, 106, 10, {1'b1, 8'hA5, 1'b0});
        chk("rm_a5_valid", ov0, 1);
        chk("rm_a5_data", od0, 'hA5);
        chk("rm_a5_perr", pe0, 0);
        chk("rm_a5_ferr", fe0, 0);
        chk("rm_a5_count", cnt0, 1);

        // 7E1: 0x55 needs parity 0, first sent with 1
        send_bits(1, 16, 10, {1'b1, 1'b1, 7'h55, 1'b0});
        send_bits(1, 16, 10, {1'b1, 1'b0, 7'h55, 1'b0});
        chk("pe_count", cnt1, 2);
        chk("pe_data", od1, 'h55);
        chk("pe_perr", pe1, 1);
        chk("pe_ferr", fe1, 0);
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        chk("pe2_data", od1, 'h55);
        chk("pe2_perr", pe1, 0);
        chk("pe2_count", cnt1, 1);

        // depth-4 FIFO overflow
        for (int i = 1; i <= 5; i++) begin
            ovr_seen = 0;
            fork
                send_bits(2, 16, 10, {1'b1, 8'(i), 1'b0});
                repeat (160) begin
                    tick();
                    if (ovr2) ovr_seen++;
                end
            join
            chk($sformatf("ovr_frame%0d", i), ovr_seen,
                (i == 5) ? 1 : 0);
        end
        chk("ovr_count", cnt2, 4);
        rdy2 = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("drain%0d_valid", j), ov2, 1);
            chk($sformatf("drain%0d_data", j), od2, j);
            tick();
        end
        chk("drain_empty", ov2, 0);
        chk("drain_count", cnt2, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_capture.md
# uart_rx_capture

Parametrised, synthesizable UART receiver with an output FIFO and per-byte error flags. It receives the SoC's `ser_tx` line and gives benches and FPGA debug harnesses a byte stream with a ready/valid interface, replacing the fixed 8N1, fixed-rate bit sampling done behaviourally today. It supports configurable bit period, data width, parity, stop-bit count and buffer depth, and reports framing, parity and overrun errors.

## Interface
- CLKS_PER_BIT, 106, clock cycles per UART bit; must be ≥ 4.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 16, number of FIFO entries; power of two, ≥ 2.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- out_data  out  DATA_BITS  head-of-FIFO data; the first received bit is the LSB.
- out_parity_err  out  1  parity error flag of the head entry.
- out_frame_err  out  1  framing error flag of the head entry.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer accepts the head entry when out_valid && out_ready.
- overrun  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.
- busy  out  1  FSM is not in IDLE.

## Operation
- rx passes through a 2-FF synchronizer. Both flops reset to 1. `rxs` is the synchronized value.
- FSM states:
  - IDLE:
    - rxs==0 → START, and the bit counter loads CLKS_PER_BIT/2 − 1 (integer division).
  - START: wait for the counter to reach 0, then sample rxs.
    - rxs==1 (glitch) → IDLE; nothing is pushed.
    - rxs==0 → DATA, with bit_idx=0 and the counter loaded with CLKS_PER_BIT − 1.
  - DATA: on each counter expiry, shift rxs in LSB-first and reload the counter. After DATA_BITS samples → PARITY if PARITY≠0, otherwise → STOP.
  - PARITY: sample the parity bit once.
    - Odd parity: the XOR of data and parity bit must equal 1. Even parity: it must equal 0.
    - A mismatch sets the parity-error latch. Then → STOP.
  - STOP: sample STOP_BITS stop bits, each one full period apart.
    - Any stop sample equal to 0 sets the frame-error latch.
    - After the last stop sample, push {frame_err, parity_err, data} to the FIFO.
    - If frame_err is set → BREAK, otherwise → IDLE.
  - BREAK: wait for rxs==1, then → IDLE. This stops a held-low line from re-triggering on every frame.
- The error latches clear on entry to DATA.
- FIFO behaviour:
  - Push when not full. Pop on out_valid && out_ready.
  - Push and pop in the same cycle while full: both happen, and count is unchanged.
  - Push while full without a pop: the frame is dropped and overrun pulses.
  - Push and pop in the same cycle while empty: the push is stored and count becomes 1. Show-ahead does not bypass to the output in that cycle.
- Reset mid-frame aborts the frame and empties the FIFO; no partial byte is pushed.
- Reset values:
  - out_valid=0, out_data=0, out_parity_err=0, out_frame_err=0.
  - overrun=0, fifo_count=0, busy=0.
  - State IDLE.
- Storage contents need no reset; outputs are gated to 0 while empty.

## Timing
- Input to detection: a falling edge on rx is seen in IDLE 2 cycles later, after the synchronizer.
- Sample points: all samples are at mid-bit. With the start edge seen at cycle 0, sample k (k=0 is the start bit) occurs at cycle CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- Push: the FIFO write happens on the clock edge after the last stop sample. fifo_count and out_valid update one cycle after the push.
- Pop: when out_valid && out_ready at edge n, the next entry (or empty) is presented after edge n. This gives full throughput of 1 entry per cycle.
- overrun is asserted for exactly the one cycle in which the push would have occurred.
- Back-to-back frames: IDLE is re-entered in the cycle after the push, so a start edge arriving half a bit after the stop sample is caught.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the parity constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - the FIFO entry width function DATA_BITS+2.
- Sub-module `sync_fifo` is parametrised by WIDTH and DEPTH and provides push, pop, full, empty, count and show-ahead read. Its pointers are one bit wider than the address so that full and empty can be told apart.
- Everything else (FSM, counters, shift register, error latches) lives in the top level.

## Test plan
- 8N1 defaults, send 0x41 → out_valid rises 1 cycle after the push (~1015 cycles after the start edge); out_data=0x41 with both error flags 0. Consumer holds out_ready=1, so fifo_count returns to 0.
- PARITY=2 (even), DATA_BITS=7, send 0x55 with the parity bit forced to 1 → out_data=0x55, out_parity_err=1, out_frame_err=0.
- Stop bit driven to 0 and rx held low for 3 bit periods → one entry with out_frame_err=1. busy stays 1 until rx returns high. No further bytes are received.
- FIFO_DEPTH=4, out_ready=0, send 0x01..0x05 → fifo_count=4 and overrun pulses once, on frame 5. Then raise out_ready → 0x01, 0x02, 0x03, 0x04 come out on consecutive cycles.
- rx low for 20 cycles (less than CLKS_PER_BIT/2) → FSM returns to IDLE, nothing is pushed, no errors.
- Assert reset for 1 cycle during the DATA state of a frame, with 2 entries queued → fifo_count=0 and out_valid=0. The next clean frame 0xA5 is received correctly.
